imem_loader: RTL and testbench

Writes programs into the instruction memory that the core fetches from, so images can be loaded without rebuilding the memory init file. It accepts a little-endian byte stream over a valid/ready handshake and packs the bytes into 32-bit words. Each word is written to consecutive word-aligned addresses, starting at 0. While loading, the core is held in reset; it is released once the last word is written.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/word_packer.sv | 35 +++
 rtl/imem_loader.sv | 118 +++++++++++
 tb/tb_imem_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The FSM state encoding and word geometry live here so packer and top agree.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  // States in which a new load may be started.
  function automatic logic can_start(input loader_state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles a little-endian byte stream into 32-bit words.
// Byte 0 of each word ends up in bits [7:0] after four shifts.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        last_byte
);

  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [31:0]           shift_reg;

  // Bytes enter at the top and move down, so the first byte lands lowest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else if (clr) begin
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else if (shift_en) begin
      byte_cnt  <= byte_cnt + 1'b1;
      shift_reg <= {byte_in, shift_reg[31:8]};
    end
  end

  assign word_out  = shift_reg;
  assign last_byte = (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory as word writes, holding the
// core in reset until the final word has been written.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-2:0] num_words,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     cpu_rst,
  output logic                     busy,
  output logic                     done
);

  loader_state_t            state;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [ADDRESS_WIDTH-2:0] words_left;
  logic                     start_ok;
  logic                     shift_en;
  logic                     last_byte;
  logic [31:0]              word;

  assign start_ok = start && can_start(state);
  // byte_ready is high exactly in RECV, so it gates acceptance directly.
  assign shift_en = byte_valid && byte_ready;

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .shift_en  (shift_en),
    .byte_in   (byte_data),
    .word_out  (word),
    .last_byte (last_byte)
  );

  // The packer register already holds the complete word during WRITE.
  assign wr_data = word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      words_left <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            if (num_words == '0) begin
              state      <= DONE;
              byte_ready <= 1'b0;
              cpu_rst    <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              state      <= RECV;
              addr       <= '0;
              words_left <= num_words;
              byte_ready <= 1'b1;
              cpu_rst    <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
            end
          end
        end

        RECV: begin
          if (shift_en && last_byte) begin
            state      <= WRITE;
            byte_ready <= 1'b0;
            wr_en      <= 1'b1;
            wr_addr    <= addr;
          end
        end

        WRITE: begin
          wr_en      <= 1'b0;
          addr       <= addr + ADDRESS_WIDTH'(4);
          words_left <= words_left - 1'b1;
          if (words_left == (ADDRESS_WIDTH-1)'(1)) begin
            state   <= DONE;
            cpu_rst <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          wr_en      <= 1'b0;
          cpu_rst    <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streaming, write strobes, cpu_rst/done
// sequencing, aborts by rst and ignored inputs.
module tb_imem_loader;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-2:0] num_words = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          cpu_rst;
  logic          busy;
  logic          done;

  int n_assert = 0;
  int n_fail   = 0;
  int n_bytes  = 0;
  logic [47:0] wq[$];

  imem_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Log writes and accepted bytes mid-cycle; byte_ready must only appear in RECV.
  always @(negedge clk) begin
    if (wr_en) wq.push_back({wr_addr, wr_data});
    if (byte_valid && byte_ready) n_bytes++;
    if (byte_ready) chk("ready_only_in_recv", {45'd0, busy, wr_en, done}, 48'b100);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-2:0] n);
    start     = 1'b1;
    num_words = n;
    tick();
    start     = 1'b0;
    num_words = '0;
  endtask

  // Present one byte until accepted; returns one step after the accepting edge.
  task automatic send(input logic [7:0] b, input bit rnd);
    int  guard;
    bit  xfer;
    guard     = 0;
    xfer      = 1'b0;
    byte_data = b;
    do begin
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      xfer       = byte_valid && byte_ready;
      tick();
      guard++;
    end while (!xfer && guard < 200);
    byte_valid = 1'b0;
    if (!xfer) chk("send_timeout", 48'd0, 48'd1);
  endtask

  task automatic send_prog(input bit rnd);
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    for (int i = 0; i < 8; i++) begin
      send(prog[i], rnd);
      if (i == 3) chk("wr_en_after_byte3", {47'd0, wr_en}, 48'd1);
    end
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1;
    tick();
    tick();
    chk("rst_byte_ready", {47'd0, byte_ready}, 48'd0);
    chk("rst_cpu_rst",    {47'd0, cpu_rst}, 48'd1);
    chk("rst_busy_done",  {46'd0, busy, done}, 48'd0);
    chk("rst_wr",         {wr_en, 15'd0, wr_addr, wr_data[15:0]}, 48'd0);
    chk("rst_wr_data",    {16'd0, wr_data}, 48'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("idle_cpu_rst",    {47'd0, cpu_rst}, 48'd1);
    chk("idle_byte_ready", {47'd0, byte_ready}, 48'd0);
    chk("idle_no_writes",  48'(wq.size()), 48'd0);

    // Two-word load, byte_valid held high
    pulse_start(15'd2);
    chk("start_busy_ready", {46'd0, busy, byte_ready}, 48'b11);
    send_prog(1'b0);
    chk("last_wr_en", {47'd0, wr_en}, 48'd1);
    tick();
    chk("done_after_last", {45'd0, done, cpu_rst, busy}, 48'b100);
    chk("load1_count", 48'(wq.size()), 48'd2);
    if (wq.size() == 2) begin
      chk("load1_w0", wq[0], 48'h0000_0050_0513);
      chk("load1_w1", wq[1], 48'h0004_0010_0593);
    end
    chk("load1_bytes", 48'(n_bytes), 48'd8);

    // Same load with random stalls, restarted from DONE
    wq.delete();
    n_bytes = 0;
    pulse_start(15'd2);
    chk("restart_cpu_rst", {46'd0, cpu_rst, done}, 48'b10);
    send_prog(1'b1);
    tick();
    chk("stall_done", {46'd0, done, cpu_rst}, 48'b10);
    chk("stall_count", 48'(wq.size()), 48'd2);
    if (wq.size() == 2) begin
      chk("stall_w0", wq[0], 48'h0000_0050_0513);
      chk("stall_w1", wq[1], 48'h0004_0010_0593);
    end
    chk("stall_bytes", 48'(n_bytes), 48'd8);

    // Zero-length load from IDLE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wq.delete();
    pulse_start(15'd0);
    chk("zero_state", {45'd0, done, cpu_rst, busy}, 48'b100);
    tick();
    chk("zero_no_write", 48'(wq.size()), 48'd0);

    // Abort mid-word with rst, then a clean one-word load
    pulse_start(15'd1);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_ready_busy", {45'd0, byte_ready, busy, done}, 48'd0);
    chk("abort_cpu_rst",    {47'd0, cpu_rst}, 48'd1);
    chk("abort_wr",         {wr_en, 15'd0, wr_addr, 16'd0}, 48'd0);
    chk("abort_wr_data",    {16'd0, wr_data}, 48'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("abort_no_write", 48'(wq.size()), 48'd0);
    pulse_start(15'd1);
    send(8'hEF, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hAD, 1'b0);
    send(8'hDE, 1'b0);
    tick();
    chk("dead_done", {47'd0, done}, 48'd1);
    chk("dead_count", 48'(wq.size()), 48'd1);
    if (wq.size() == 1) chk("dead_word", wq[0], 48'h0000_DEAD_BEEF);

    // start while busy is ignored
    wq.delete();
    pulse_start(15'd2);
    send(8'h01, 1'b0);
    pulse_start(15'd5);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b0);
    tick();
    chk("busy_start_done", {47'd0, done}, 48'd1);
    chk("busy_start_count", 48'(wq.size()), 48'd2);
    if (wq.size() == 2) begin
      chk("busy_start_w0", wq[0], 48'h0000_0403_0201);
      chk("busy_start_w1", wq[1], 48'h0004_1312_1110);
    end

    // byte_valid in DONE is ignored, then restart writes from address 0
    byte_data  = 8'h77;
    byte_valid = 1'b1;
    tick();
    tick();
    byte_valid = 1'b0;
    chk("done_byte_ready", {47'd0, byte_ready}, 48'd0);
    wq.delete();
    pulse_start(15'd1);
    chk("restart2_cpu_rst", {46'd0, cpu_rst, done}, 48'b10);
    send(8'h44, 1'b0);
    send(8'h33, 1'b0);
    send(8'h22, 1'b0);
    send(8'h11, 1'b0);
    tick();
    chk("restart2_count", 48'(wq.size()), 48'd1);
    if (wq.size() == 1) chk("restart2_word", wq[0], 48'h0000_1122_3344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
